// File: rtl/r_pipe_pkg.sv
// r_pipe_pkg: shared definitions for the five-stage R-type pipeline.
//   - opcode/funct encodings of the supported R-type instructions
//   - ALU operation and forwarding-source enums
//   - pipeline register structs (control fields only; the DATA_W-wide data
//     fields live next to them in the core because a package cannot be
//     parameterised by DATA_W)
//   - decode helper mapping opcode/funct to an ALU op plus a "supported" flag
package r_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt,
        AluSll,
        AluSrl
    } alu_op_e;

    typedef enum logic [1:0] {
        FwdNone,
        FwdExMem,
        FwdMemWb
    } fwd_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        alu_op_e     op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
    } id_ex_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } mem_wb_t;

    typedef struct packed {
        logic    ok;
        alu_op_e op;
    } dec_t;

    function automatic dec_t decode_instr(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d.ok = 1'b1;
        d.op = AluAdd;
        if (opcode != OP_RTYPE) begin
            d.ok = 1'b0;
        end else begin
            case (funct)
                FN_ADD:  d.op = AluAdd;
                FN_SUB:  d.op = AluSub;
                FN_AND:  d.op = AluAnd;
                FN_OR:   d.op = AluOr;
                FN_SLT:  d.op = AluSlt;
                FN_SLL:  d.op = AluSll;
                FN_SRL:  d.op = AluSrl;
                default: d.ok = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/r_fwd_unit.sv
// r_fwd_unit: combinational forwarding-source select for the two EX operands.
// A source is forwarded from a later stage when that stage is valid, writes a
// non-zero register and that register matches the source index. EX/MEM holds
// the younger result, so it wins over MEM/WB.
// Ports:
//   rs, rt         in   source indices of the instruction in ID/EX
//   exmem_valid/rd in   EX/MEM valid bit and destination
//   memwb_valid/rd in   MEM/WB valid bit and destination
//   sel_a, sel_b   out  fwd_sel_e encoding for operand A (rs) and B (rt)
module r_fwd_unit
    import r_pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       exmem_valid,
    input  logic [4:0] exmem_rd,
    input  logic       memwb_valid,
    input  logic [4:0] memwb_rd,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b
);

    function automatic fwd_sel_e pick(input logic [4:0] src,
                                      input logic       ex_v,
                                      input logic [4:0] ex_rd,
                                      input logic       wb_v,
                                      input logic [4:0] wb_rd);
        if (ex_v && (ex_rd != 5'd0) && (ex_rd == src)) begin
            return FwdExMem;
        end
        if (wb_v && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return FwdMemWb;
        end
        return FwdNone;
    endfunction

    always_comb begin
        sel_a = pick(rs, exmem_valid, exmem_rd, memwb_valid, memwb_rd);
        sel_b = pick(rt, exmem_valid, exmem_rd, memwb_valid, memwb_rd);
    end

endmodule

// File: rtl/r_pipeline_fwd_core.sv
// r_pipeline_fwd_core: parametrised five-stage (IF/ID/EX/MEM/WB) R-type core
// with per-stage valid bits, a fetch handshake, a write-first register-file
// bypass and optional EX-stage operand forwarding.
// Build option: define R_PIPE_FWD_EN to compile in forwarding from EX/MEM and
// MEM/WB; without it EX uses only the operands captured in ID/EX.
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   imem_addr   current PC to the instruction memory
//   imem_instr  instruction at imem_addr (combinational)
//   imem_valid  imem_instr valid; when low a bubble is fetched and PC holds
//   wb_valid    a register write happens at the next edge (never for $0)
//   wb_rd       destination of that write
//   wb_data     write data
//   retired     count of completed register writes (wraps at 2^32)
module r_pipeline_fwd_core
    import r_pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NREG        = 32,
    parameter int unsigned RF_INIT_IDX = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              imem_valid,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       retired
);

    localparam int unsigned RIDX_W    = (NREG > 1) ? $clog2(NREG) : 1;
    // Index bits above log2(NREG) are ignored by masking them at decode.
    localparam logic [4:0]  RIDX_MASK = 5'(NREG - 1);

    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       retired_q;
    logic [DATA_W-1:0] rf_q [NREG];

    if_id_t  ifid_q;
    id_ex_t  idex_q;
    ex_mem_t exmem_q;
    mem_wb_t memwb_q;

    logic [DATA_W-1:0] idex_a_q, idex_b_q, exmem_res_q, memwb_res_q;

    // ---------------------------------------------------------------- ID
    dec_t              dec;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_a, id_b;

    always_comb begin
        id_rs = ifid_q.instr[25:21] & RIDX_MASK;
        id_rt = ifid_q.instr[20:16] & RIDX_MASK;
        id_rd = ifid_q.instr[15:11] & RIDX_MASK;
        dec   = decode_instr(ifid_q.instr[31:26], ifid_q.instr[5:0]);
    end

    // Register read with write-first bypass from the WB stage.
    always_comb begin
        id_a = rf_q[id_rs[RIDX_W-1:0]];
        if (id_rs == 5'd0) begin
            id_a = '0;
        end else if (wb_valid && (wb_rd == id_rs)) begin
            id_a = wb_data;
        end
        id_b = rf_q[id_rt[RIDX_W-1:0]];
        if (id_rt == 5'd0) begin
            id_b = '0;
        end else if (wb_valid && (wb_rd == id_rt)) begin
            id_b = wb_data;
        end
    end

    // ---------------------------------------------------------------- EX
    logic [DATA_W-1:0] op_a, op_b, ex_res;

`ifdef R_PIPE_FWD_EN
    logic [1:0] sel_a, sel_b;

    r_fwd_unit u_fwd (
        .rs          (idex_q.rs),
        .rt          (idex_q.rt),
        .exmem_valid (exmem_q.valid),
        .exmem_rd    (exmem_q.rd),
        .memwb_valid (memwb_q.valid),
        .memwb_rd    (memwb_q.rd),
        .sel_a       (sel_a),
        .sel_b       (sel_b)
    );

    always_comb begin
        case (fwd_sel_e'(sel_a))
            FwdExMem: op_a = exmem_res_q;
            FwdMemWb: op_a = memwb_res_q;
            default:  op_a = idex_a_q;
        endcase
        case (fwd_sel_e'(sel_b))
            FwdExMem: op_b = exmem_res_q;
            FwdMemWb: op_b = memwb_res_q;
            default:  op_b = idex_b_q;
        endcase
    end
`else
    assign op_a = idex_a_q;
    assign op_b = idex_b_q;
`endif

    // Logical shifts by >= DATA_W already produce zero, so shamt needs no clamp.
    always_comb begin
        ex_res = '0;
        case (idex_q.op)
            AluAdd:  ex_res = op_a + op_b;
            AluSub:  ex_res = op_a - op_b;
            AluAnd:  ex_res = op_a & op_b;
            AluOr:   ex_res = op_a | op_b;
            AluSlt:  ex_res = DATA_W'($signed(op_a) < $signed(op_b));
            AluSll:  ex_res = op_b << idex_q.shamt;
            AluSrl:  ex_res = op_b >> idex_q.shamt;
            default: ex_res = '0;
        endcase
    end

    // ---------------------------------------------------------------- WB
    assign wb_valid  = memwb_q.valid && (memwb_q.rd != 5'd0);
    assign wb_rd     = memwb_q.rd;
    assign wb_data   = memwb_res_q;
    assign retired   = retired_q;
    assign imem_addr = pc_q;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            ifid_q      <= '0;
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            idex_a_q    <= '0;
            idex_b_q    <= '0;
            exmem_res_q <= '0;
            memwb_res_q <= '0;
            retired_q   <= '0;
        end else begin
            if (imem_valid) begin
                pc_q         <= pc_q + ADDR_W'(4);
                ifid_q.valid <= 1'b1;
                ifid_q.instr <= imem_instr;
            end else begin
                ifid_q       <= '0;
            end

            // Unsupported encodings enter ID/EX as bubbles.
            idex_q.valid <= ifid_q.valid && dec.ok;
            idex_q.op    <= dec.op;
            idex_q.rs    <= id_rs;
            idex_q.rt    <= id_rt;
            idex_q.rd    <= id_rd;
            idex_q.shamt <= ifid_q.instr[10:6];
            idex_a_q     <= id_a;
            idex_b_q     <= id_b;

            exmem_q.valid <= idex_q.valid;
            exmem_q.rd    <= idex_q.rd;
            exmem_res_q   <= ex_res;

            memwb_q     <= exmem_q;
            memwb_res_q <= exmem_res_q;

            if (wb_valid) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i[RIDX_W-1:0]] <= (RF_INIT_IDX == 1) ? DATA_W'(i) : '0;
            end
        end else if (wb_valid) begin
            rf_q[memwb_q.rd[RIDX_W-1:0]] <= memwb_res_q;
        end
    end

endmodule

// File: tb/tb_r_pipeline_fwd_core.sv
// tb_r_pipeline_fwd_core: directed scoreboard bench for r_pipeline_fwd_core.
// The stimulus thread pushes the hand-computed writeback of every issued
// instruction into a queue; a monitor pops and compares on each wb_valid.
// Expected values that depend on forwarding follow R_PIPE_FWD_EN.
module tb_r_pipeline_fwd_core;
    import r_pipe_pkg::*;

`ifdef R_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_valid;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retired;

    r_pipeline_fwd_core #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .NREG        (32),
        .RF_INIT_IDX (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .imem_valid (imem_valid),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_count = 0;
    logic [31:0] pc_model = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    task automatic cyc(input logic [31:0] ins, input logic v);
        imem_instr = ins;
        imem_valid = v;
        @(posedge clk);
        #1;
        if (v && !rst) pc_model += 32'd4;
    endtask

    task automatic issue(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] sh, input logic [31:0] d);
        exp_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
        exp_count++;
        cyc(rtype(fn, rd, rs, rt, sh), 1'b1);
    endtask

    task automatic drain();
        repeat (5) cyc(32'h0, 1'b0);
    endtask

    // Monitor: every writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wb: got rd=%0d data=%h, expected no write",
                         wb_rd, wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                check("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc_hold;
        rst        = 1'b1;
        imem_instr = '0;
        imem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_pc", imem_addr, 32'h0);
        check("reset_retired", retired, 32'h0);
        check("reset_wb_valid", {31'b0, wb_valid}, 32'h0);
        check("reset_wb_rd", {27'b0, wb_rd}, 32'h0);
        check("reset_wb_data", wb_data, 32'h0);

        // Basic add from reset register values.
        issue(FN_ADD, 5'd3, 5'd1, 5'd2, 5'd0, 32'd3);
        drain();
        check("retired_after_first", retired, 32'd1);
        check("pc_after_first", imem_addr, pc_model);

        // Distance 1: EX/MEM forwarding (stale $4=4 without it).
        issue(FN_ADD, 5'd4, 5'd1, 5'd2, 5'd0, 32'd3);
        issue(FN_SUB, 5'd5, 5'd4, 5'd1, 5'd0, FWD ? 32'd2 : 32'd3);
        drain();

        // Distance 2: MEM/WB forwarding (stale $6=6 without it).
        issue(FN_OR,  5'd6,  5'd2, 5'd4, 5'd0, 32'd3);
        issue(FN_AND, 5'd13, 5'd1, 5'd3, 5'd0, 32'd1);
        issue(FN_ADD, 5'd7,  5'd6, 5'd6, 5'd0, FWD ? 32'd6 : 32'd12);
        drain();

        // Distance 3: register-file write-first bypass, both builds.
        issue(FN_OR,  5'd14, 5'd2,  5'd1,  5'd0, 32'd3);
        issue(FN_AND, 5'd15, 5'd1,  5'd1,  5'd0, 32'd1);
        issue(FN_AND, 5'd16, 5'd2,  5'd2,  5'd0, 32'd2);
        issue(FN_ADD, 5'd17, 5'd14, 5'd14, 5'd0, 32'd6);
        drain();

        // EX/MEM must win over MEM/WB when both hold the same rd.
        issue(FN_ADD, 5'd25, 5'd1,  5'd1, 5'd0, 32'd2);
        issue(FN_ADD, 5'd25, 5'd25, 5'd1, 5'd0, FWD ? 32'd3 : 32'd26);
        issue(FN_ADD, 5'd26, 5'd25, 5'd0, 5'd0, FWD ? 32'd3 : 32'd25);
        drain();

        // slt (signed), shifts, bypass across fetch bubbles.
        issue(FN_SLT, 5'd8,  5'd0, 5'd1, 5'd0, 32'd1);
        issue(FN_SUB, 5'd9,  5'd0, 5'd1, 5'd0, 32'hFFFF_FFFF);
        cyc(32'h0, 1'b0);
        cyc(32'h0, 1'b0);
        issue(FN_SLT, 5'd10, 5'd9, 5'd0, 5'd0,  32'd1);
        issue(FN_SLL, 5'd11, 5'd0, 5'd1, 5'd4,  32'd16);
        issue(FN_SRL, 5'd12, 5'd0, 5'd9, 5'd28, 32'hF);
        issue(FN_ADD, 5'd18, 5'd1, 5'd1, 5'd0,  32'd2);
        cyc(32'h0, 1'b0);
        issue(FN_ADD, 5'd19, 5'd18, 5'd2, 5'd0, FWD ? 32'd4 : 32'd20);
        drain();

        // No-write cases: $0 destination, bad funct, bad opcode, invalid fetch.
        cyc(rtype(FN_ADD, 5'd0, 5'd1, 5'd2, 5'd0), 1'b1);
        cyc(rtype(6'h18, 5'd20, 5'd1, 5'd2, 5'd0), 1'b1);
        cyc({6'h08, 5'd1, 5'd2, 5'd21, 5'd0, 6'h20}, 1'b1);
        pc_hold = pc_model;
        for (int k = 0; k < 3; k++) begin
            cyc(rtype(FN_ADD, 5'd22, 5'd1, 5'd1, 5'd0), 1'b0);
            check("pc_hold_invalid_fetch", imem_addr, pc_hold);
        end
        drain();
        check("retired_no_write_cases", retired, 32'(exp_count));

        // Reset with three instructions in flight.
        cyc(rtype(FN_ADD, 5'd20, 5'd1, 5'd2, 5'd0), 1'b1);
        cyc(rtype(FN_ADD, 5'd21, 5'd1, 5'd2, 5'd0), 1'b1);
        cyc(rtype(FN_ADD, 5'd22, 5'd1, 5'd2, 5'd0), 1'b1);
        rst = 1'b1;
        cyc(32'h0, 1'b0);
        rst       = 1'b0;
        pc_model  = '0;
        exp_count = 0;
        check("midreset_pc", imem_addr, 32'h0);
        check("midreset_retired", retired, 32'h0);
        check("midreset_wb_valid", {31'b0, wb_valid}, 32'h0);
        check("midreset_wb_data", wb_data, 32'h0);
        drain();
        check("midreset_no_writes", retired, 32'h0);

        // Registers are back at their index values.
        issue(FN_ADD, 5'd21, 5'd4,  5'd0, 5'd0, 32'd4);
        issue(FN_OR,  5'd22, 5'd9,  5'd0, 5'd0, 32'd9);
        issue(FN_ADD, 5'd23, 5'd5,  5'd0, 5'd0, 32'd5);
        issue(FN_SLL, 5'd24, 5'd0, 5'd12, 5'd0, 32'd12);
        drain();
        check("retired_after_reset", retired, 32'd4);
        check("pc_after_reset", imem_addr, pc_model);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
